mem_arbiter: RTL

Two-port arbiter sharing the single-port unified instruction/data memory of the PakRV core between the fetch stage and the load/store unit. It translates byte addresses into word indices relative to the memory base and range-checks them. It issues at most one memory access per cycle and routes each synchronous-read result back to the requester that issued it. It sits between the core pipeline and the memory array, replacing direct dual-port access.

---
 rtl/mem_pkg.sv | 19 +
 rtl/mem_addr_xlate.sv | 29 ++
 rtl/mem_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the PakRV unified-memory arbiter.
// Contents: response-owner tag enum, default memory base, grant-pointer encodings.
// No logic; imported by mem_addr_xlate and mem_arbiter.
package mem_pkg;

  // Which requester owns the read data returning from memory this cycle.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_RSP = 2'd1,
    DM_RSP = 2'd2
  } rsp_owner_e;

  localparam logic [31:0] MEM_BASE_DEFAULT = 32'h8000_0000;

  // Encodings of the "last granted port" pointer used under contention.
  localparam logic GRANT_IF = 1'b0;
  localparam logic GRANT_DM = 1'b1;

endpackage

// File: rtl/mem_addr_xlate.sv
// Purpose: byte address -> word index relative to MEM_BASE, with range check.
// Latency: purely combinational.
// Backpressure: none; pure function of addr.
// Ports: addr (byte address in), in_range (offset < MEM_WORDS*4), idx (word index out).
module mem_addr_xlate
  import mem_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] MEM_BASE   = ADDR_WIDTH'(MEM_BASE_DEFAULT),
  parameter int                    MEM_WORDS  = 262144,
  parameter int                    IDX_WIDTH  = $clog2(MEM_WORDS)
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  in_range,
  output logic [IDX_WIDTH-1:0]  idx
);

  localparam logic [63:0] LIMIT = 64'(MEM_WORDS) * 64'd4;

  logic [ADDR_WIDTH-1:0] offset;

  // Wraps modulo 2^ADDR_WIDTH, so addresses below the base become huge
  // offsets and fail the range check naturally.
  assign offset   = addr - MEM_BASE;
  assign in_range = 64'(offset) < LIMIT;
  // Byte lane bits [1:0] are dropped: accesses are always whole words.
  assign idx      = offset[IDX_WIDTH+1:2];

endmodule

// File: rtl/mem_arbiter.sv
// Purpose: shares the single-port unified I/D memory between fetch (if_*) and load/store (dm_*).
// Latency: request granted in cycle T -> response strobe in T+1; one access per cycle.
// Backpressure: loser under contention sees req_ready=0 and must hold its request; responses cannot be stalled.
// Ports: clk/rst (sync, active-high); if_req_*/if_rsp_* fetch port; dm_req_*/dm_rsp_* data port;
//        mem_* drive the memory array (combinational), mem_rdata returns one cycle after mem_en.
// Build option: MEM_ARB_RR_EN selects round-robin under contention; default is data-over-fetch priority.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] MEM_BASE   = ADDR_WIDTH'(MEM_BASE_DEFAULT),
  parameter int                    MEM_WORDS  = 262144,
  localparam int                   MASK_SIZE  = DATA_WIDTH / 8,
  localparam int                   IDX_WIDTH  = $clog2(MEM_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_valid,
  output logic                  if_req_ready,
  input  logic [ADDR_WIDTH-1:0] if_req_addr,
  output logic                  if_rsp_valid,
  output logic [DATA_WIDTH-1:0] if_rsp_data,
  output logic                  if_rsp_err,
  input  logic                  dm_req_valid,
  output logic                  dm_req_ready,
  input  logic                  dm_req_we,
  input  logic [MASK_SIZE-1:0]  dm_req_mask,
  input  logic [ADDR_WIDTH-1:0] dm_req_addr,
  input  logic [DATA_WIDTH-1:0] dm_req_wdata,
  output logic                  dm_rsp_valid,
  output logic [DATA_WIDTH-1:0] dm_rsp_data,
  output logic                  dm_rsp_err,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [MASK_SIZE-1:0]  mem_mask,
  output logic [IDX_WIDTH-1:0]  mem_idx,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  logic                 if_in_range, dm_in_range;
  logic [IDX_WIDTH-1:0] if_idx, dm_idx;
  logic                 if_gnt, dm_gnt, dm_wins;

  rsp_owner_e state_q, state_d;
  logic       err_q, err_d;
  logic       zero_q, zero_d;  // response carries 0 instead of mem_rdata

  mem_addr_xlate #(
    .ADDR_WIDTH(ADDR_WIDTH), .MEM_BASE(MEM_BASE), .MEM_WORDS(MEM_WORDS), .IDX_WIDTH(IDX_WIDTH)
  ) u_if_xlate (
    .addr(if_req_addr), .in_range(if_in_range), .idx(if_idx)
  );

  mem_addr_xlate #(
    .ADDR_WIDTH(ADDR_WIDTH), .MEM_BASE(MEM_BASE), .MEM_WORDS(MEM_WORDS), .IDX_WIDTH(IDX_WIDTH)
  ) u_dm_xlate (
    .addr(dm_req_addr), .in_range(dm_in_range), .idx(dm_idx)
  );

`ifdef MEM_ARB_RR_EN
  logic last_gnt_q;

  // On conflict the port that did not win last time goes next; starting at
  // "fetch last" hands the first conflict after reset to data.
  assign dm_wins = (last_gnt_q == GRANT_IF);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt_q <= GRANT_IF;
    end else if (dm_gnt || if_gnt) begin
      last_gnt_q <= dm_gnt ? GRANT_DM : GRANT_IF;
    end
  end
`else
  assign dm_wins = 1'b1;
`endif

  // No grants while in reset: an accepted request would lose its response
  // when the tag register clears.
  assign dm_gnt = !rst && dm_req_valid && (!if_req_valid || dm_wins);
  assign if_gnt = !rst && if_req_valid && !dm_gnt;

  assign dm_req_ready = dm_gnt;
  assign if_req_ready = if_gnt;

  // Out-of-range grants still complete (with err) but never touch memory.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_mask  = '0;
    mem_idx   = '0;
    mem_wdata = '0;
    if (dm_gnt && dm_in_range) begin
      mem_en    = 1'b1;
      mem_we    = dm_req_we;
      mem_mask  = dm_req_we ? dm_req_mask : '0;
      mem_idx   = dm_idx;
      mem_wdata = dm_req_we ? dm_req_wdata : '0;
    end else if (if_gnt && if_in_range) begin
      mem_en  = 1'b1;
      mem_idx = if_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d      = IDLE;
    err_d        = 1'b0;
    zero_d       = 1'b0;
    if_rsp_valid = 1'b0;
    if_rsp_data  = '0;
    if_rsp_err   = 1'b0;
    dm_rsp_valid = 1'b0;
    dm_rsp_data  = '0;
    dm_rsp_err   = 1'b0;

    if (dm_gnt) begin
      state_d = DM_RSP;
      err_d   = !dm_in_range;
      zero_d  = !dm_in_range || dm_req_we;
    end else if (if_gnt) begin
      state_d = IF_RSP;
      err_d   = !if_in_range;
      zero_d  = !if_in_range;
    end

    // Gating with rst drops a response that is in flight when reset arrives.
    if (!rst) begin
      case (state_q)
        IF_RSP: begin
          if_rsp_valid = 1'b1;
          if_rsp_data  = zero_q ? '0 : mem_rdata;
          if_rsp_err   = err_q;
        end
        DM_RSP: begin
          dm_rsp_valid = 1'b1;
          dm_rsp_data  = zero_q ? '0 : mem_rdata;
          dm_rsp_err   = err_q;
        end
        default: ;
      endcase
    end
  end

endmodule
